// File: rtl/ws2812_receiver.sv
`timescale 1ns/1ps
// WS2812B serial receiver: decodes GRB pixels from a single-wire strand,
// reports each pixel with its index, and flags frame ends and malformed input.
module ws2812_receiver #(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned NUM_LEDS    = 20
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        strand_in,
  output logic [7:0]                  green_out,
  output logic [7:0]                  red_out,
  output logic [7:0]                  blue_out,
  output logic                        pixel_valid,
  output logic [$clog2(NUM_LEDS)-1:0] pixel_index,
  output logic                        frame_done,
  output logic                        bit_error,
  output logic                        overflow
);

  // Cycle thresholds derived from the clock rate
  localparam int unsigned MHZ        = CLOCK_SPEED / 1_000_000;
  localparam int unsigned MIN_H_CYC  = MHZ * 150 / 1000;
  localparam int unsigned THRESH_CYC = MHZ * 600 / 1000;
  localparam int unsigned MAX_H_CYC  = MHZ * 1100 / 1000;
  localparam int unsigned RES_CYC    = MHZ * 50;

  localparam int unsigned H_W   = $clog2(MAX_H_CYC + 1);
  localparam int unsigned G_W   = $clog2(RES_CYC);
  localparam int unsigned P_W   = $clog2(NUM_LEDS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_LEDS);

  typedef enum logic [1:0] {RESYNC, IDLE, HIGH, LOW} state_t;

  state_t         state_q, state_d;
  logic           sync_q1, line_q;
  logic [H_W-1:0] high_cnt;
  logic [G_W-1:0] gap_cnt;
  logic [4:0]     bit_cnt;
  logic [P_W-1:0] pix_cnt;
  logic [22:0]    shift_q;

  logic rise_c, hi_inc_c, hi_long_c, fall_c, short_c;
  logic bit_ok_c, bit_val_c, err_c, frame_end_c, resync_done_c;

  // Two-flop synchronizer for the asynchronous strand
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q1 <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      sync_q1 <= strand_in;
      line_q  <= sync_q1;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= RESYNC;
    else           state_q <= state_d;
  end

  // Decode line events and pulse classification for the current state
  always_comb begin
    rise_c        = line_q && (state_q == IDLE || state_q == LOW);
    hi_inc_c      = (state_q == HIGH) && line_q && (high_cnt != H_W'(MAX_H_CYC));
    hi_long_c     = (state_q == HIGH) && line_q && (high_cnt == H_W'(MAX_H_CYC));
    fall_c        = (state_q == HIGH) && !line_q;
    short_c       = fall_c && (high_cnt < H_W'(MIN_H_CYC));
    bit_ok_c      = fall_c && !short_c;
    bit_val_c     = (high_cnt >= H_W'(THRESH_CYC));
    err_c         = hi_long_c || short_c;
    frame_end_c   = (state_q == LOW) && !line_q && (gap_cnt == G_W'(RES_CYC - 1));
    resync_done_c = (state_q == RESYNC) && !line_q && (gap_cnt == G_W'(RES_CYC - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESYNC: if (resync_done_c) state_d = IDLE;
      IDLE:   if (line_q) state_d = HIGH;
      HIGH: begin
        if (err_c)         state_d = RESYNC;
        else if (bit_ok_c) state_d = LOW;
      end
      LOW: begin
        if (line_q)           state_d = HIGH;
        else if (frame_end_c) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  // Counters, bit assembly and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      high_cnt    <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shift_q     <= '0;
      green_out   <= '0;
      red_out     <= '0;
      blue_out    <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;

      if (rise_c)        high_cnt <= H_W'(1);
      else if (hi_inc_c) high_cnt <= high_cnt + H_W'(1);

      // One counter serves both the resync low-run and the inter-bit low time
      if (state_q == RESYNC)          gap_cnt <= (line_q || resync_done_c) ? '0 : gap_cnt + G_W'(1);
      else if (bit_ok_c)              gap_cnt <= G_W'(1);
      else if (state_q == LOW && !line_q) gap_cnt <= frame_end_c ? '0 : gap_cnt + G_W'(1);
      else if (err_c)                 gap_cnt <= '0;

      if (err_c) begin
        // Partial pixel is discarded; pixel count and overflow survive until frame end
        bit_error <= 1'b1;
        bit_cnt   <= '0;
      end else if (bit_ok_c) begin
        shift_q <= {shift_q[21:0], bit_val_c};
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          if (pix_cnt < P_W'(NUM_LEDS)) begin
            green_out   <= shift_q[22:15];
            red_out     <= shift_q[14:7];
            blue_out    <= {shift_q[6:0], bit_val_c};
            pixel_valid <= 1'b1;
            pixel_index <= IDX_W'(pix_cnt);
            pix_cnt     <= pix_cnt + P_W'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else if (frame_end_c) begin
        frame_done <= (bit_cnt != '0) || (pix_cnt != '0);
        bit_error  <= (bit_cnt != '0);
        bit_cnt    <= '0;
        pix_cnt    <= '0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_receiver.sv
`timescale 1ns/1ps
// Scoreboard bench for ws2812_receiver: a pulse-level model queues expected
// pixels and frame/error events; a monitor pops them as the DUT reports.
module tb_ws2812_receiver;

  localparam int NUM    = 20;
  localparam int MIN_H  = 15;
  localparam int THRESH = 60;
  localparam int MAX_H  = 110;
  localparam int RES    = 5000;
  localparam int GAP    = RES + 10;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       strand_in = 1'b0;
  logic [7:0] green_out, red_out, blue_out;
  logic       pixel_valid, frame_done, bit_error, overflow;
  logic [4:0] pixel_index;

  ws2812_receiver #(.CLOCK_SPEED(100_000_000), .NUM_LEDS(NUM)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .strand_in   (strand_in),
    .green_out   (green_out),
    .red_out     (red_out),
    .blue_out    (blue_out),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .bit_error   (bit_error),
    .overflow    (overflow)
  );

  typedef struct { logic [7:0] g; logic [7:0] r; logic [7:0] b; int idx; int cyc; } pix_t;
  typedef struct { bit fd; bit be; int cyc; } evt_t;

  pix_t pix_q[$];
  evt_t evt_q[$];
  pix_t mp;
  evt_t me;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: bits of the pixel in progress, pixels this frame
  int          m_bits = 0;
  int          m_pcnt = 0;
  logic [23:0] m_shift = '0;
  bit          m_ovf = 1'b0;
  bit          m_synced = 1'b0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset();
    check("reset_green", green_out, 0);
    check("reset_red", red_out, 0);
    check("reset_blue", blue_out, 0);
    check("reset_index", pixel_index, 0);
    check("reset_pixel_valid", pixel_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_bit_error", bit_error, 0);
    check("reset_overflow", overflow, 0);
  endtask

  // One high pulse then a low time; the model predicts its effect first
  task automatic send_pulse(input int high, input int low);
    int rise = cyc;
    int fall = cyc + high;
    if (m_synced) begin
      if (high > MAX_H) begin
        // Flagged on the 111th synchronized high cycle, no falling edge needed
        evt_q.push_back('{1'b0, 1'b1, rise + (MAX_H + 1) + 2});
        m_bits = 0;
        m_synced = 1'b0;
      end else if (high < MIN_H) begin
        evt_q.push_back('{1'b0, 1'b1, -1});
        m_bits = 0;
        m_synced = 1'b0;
      end else begin
        m_shift = {m_shift[22:0], (high >= THRESH) ? 1'b1 : 1'b0};
        m_bits++;
        if (m_bits == 24) begin
          m_bits = 0;
          if (m_pcnt < NUM) begin
            pix_q.push_back('{m_shift[23:16], m_shift[15:8], m_shift[7:0], m_pcnt, fall + 3});
            m_pcnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    strand_in = 1'b1;
    repeat (high) @(negedge clk_in);
    strand_in = 1'b0;
    repeat (low) @(negedge clk_in);
  endtask

  // Long low: ends a frame if decoding, otherwise re-acquires the line
  task automatic send_gap(input int n);
    if (m_synced && (m_bits != 0 || m_pcnt != 0))
      evt_q.push_back('{1'b1, (m_bits != 0), -1});
    if (m_synced) begin
      m_bits = 0;
      m_pcnt = 0;
      m_ovf  = 1'b0;
    end
    m_synced = 1'b1;
    strand_in = 1'b0;
    repeat (n) @(negedge clk_in);
    check("overflow_after_gap", overflow, m_ovf);
  endtask

  // mode 0: 40/85 and 80/45 bits; mode 1: threshold widths; else random fast
  task automatic send_pixel(input logic [23:0] pix, input int mode);
    int ones[3]  = '{60, 110, 75};
    int zeros[3] = '{59, 15, 40};
    int k1 = 0;
    int k0 = 0;
    for (int i = 23; i >= 0; i--) begin
      int hi, lo;
      case (mode)
        0: begin
          hi = pix[i] ? 80 : 40;
          lo = pix[i] ? 45 : 85;
        end
        1: begin
          if (pix[i]) begin hi = ones[k1 % 3]; k1++; end
          else        begin hi = zeros[k0 % 3]; k0++; end
          lo = 30;
        end
        default: begin
          hi = pix[i] ? int'($urandom_range(70, 60)) : int'($urandom_range(25, 15));
          lo = int'($urandom_range(12, 5));
        end
      endcase
      send_pulse(hi, lo);
    end
    check("overflow_after_pixel", overflow, m_ovf);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) != 0) send_pulse(int'($urandom_range(70, 60)), int'($urandom_range(12, 5)));
      else                           send_pulse(int'($urandom_range(25, 15)), int'($urandom_range(12, 5)));
    end
  endtask

  // Monitor: pop and compare whenever the DUT reports a pixel or an event
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (pixel_valid) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pixel_valid", pixel_valid, 0);
        end else begin
          mp = pix_q.pop_front();
          check("pixel_green", green_out, mp.g);
          check("pixel_red", red_out, mp.r);
          check("pixel_blue", blue_out, mp.b);
          check("pixel_index", pixel_index, mp.idx);
          check("pixel_latency_cycle", cyc, mp.cyc);
        end
      end
      if (frame_done || bit_error) begin
        if (evt_q.size() == 0) begin
          check("unexpected_event", {frame_done, bit_error}, 0);
        end else begin
          me = evt_q.pop_front();
          check("event_frame_done", frame_done, me.fd);
          check("event_bit_error", bit_error, me.be);
          if (me.cyc >= 0) check("event_cycle", cyc, me.cyc);
          if (frame_done) check("overflow_at_frame_done", overflow, 0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check_reset();
    rst_n_in = 1'b1;
    send_gap(GAP);

    // Known pixel followed back-to-back by a pixel built from threshold widths
    send_pixel(24'hA53CFF, 0);
    send_pixel(24'h5AC30F, 1);
    send_gap(GAP);

    // Too-short high pulse mid-pixel; following bits ignored until a gap
    send_bits(5);
    send_pulse(14, 30);
    send_bits(3);
    send_gap(GAP);

    // Too-long high pulse
    send_pulse(150, 30);
    send_gap(GAP);

    // Partial pixel at frame end
    send_bits(12);
    send_gap(GAP);

    // One pixel more than the strand length
    for (int p = 0; p < NUM + 1; p++) send_pixel(24'($urandom), 2);
    send_gap(GAP);

    // Reset mid-pixel, then a pixel with no preceding reset gap
    send_bits(10);
    rst_n_in = 1'b0;
    #1;
    check_reset();
    m_bits = 0;
    m_pcnt = 0;
    m_ovf = 1'b0;
    m_synced = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    send_pixel(24'hC0FFEE, 2);
    send_gap(GAP);
    send_pixel(24'h0BEEF1, 2);
    send_gap(GAP);

    repeat (10) @(negedge clk_in);
    check("pending_pixels", pix_q.size(), 0);
    check("pending_events", evt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_receiver.md
WS2812_RECEIVER -- requirements
Module: ws2812_receiver

Interface
REQ-001 Parameter CLOCK_SPEED, default 100_000_000: clock frequency in Hz; all cycle thresholds are derived from it.
REQ-002 Parameter NUM_LEDS, default 20: pixels accepted per frame; index width is $clog2(NUM_LEDS).
REQ-003 Derived thresholds at 100MHz: MinHCyc=15 (150ns), ThreshCyc=60 (600ns), MaxHCyc=110 (1100ns), RESCyc=5000 (50us).
REQ-004 clk_in  input  1  system clock; one clock domain.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 strand_in  input  1  WS2812B serial line; asynchronous to clk_in.
REQ-007 green_out, red_out, blue_out  output  8 each  last decoded pixel.
REQ-008 pixel_valid  output  1  single-cycle pulse; color outputs are valid during that cycle.
REQ-009 pixel_index  output  $clog2(NUM_LEDS)  index of the pixel presented with pixel_valid.
REQ-010 frame_done  output  1  single-cycle pulse when a reset gap ends a frame that contained at least one bit.
REQ-011 bit_error  output  1  single-cycle pulse on a malformed high pulse or a partial pixel.
REQ-012 overflow  output  1  sticky flag: more than NUM_LEDS pixels were received in the current frame.

Function
REQ-013 strand_in passes through a 2-flop synchronizer; all decoding uses the synchronized signal.
REQ-014 States: RESYNC, IDLE, HIGH, LOW.
REQ-015 RESYNC: count consecutive synchronized-low cycles; a high sample clears the count; count==RESCyc-1 -> IDLE; no frame_done.
REQ-016 IDLE: rising edge -> HIGH with high counter = 1.
REQ-017 HIGH: high counter increments each high cycle.
  - Counter reaching MaxHCyc+1 -> bit_error and RESYNC; do not wait for the falling edge.
  - On a falling edge, classify the count:
    - count < MinHCyc -> bit_error, RESYNC;
    - count < ThreshCyc -> bit 0;
    - otherwise -> bit 1.
  - After classification, shift the bit in MSB-first and go to LOW with low counter = 1.
REQ-018 LOW: rising edge -> HIGH; low counter reaching RESCyc-1 -> end of frame -> IDLE.
REQ-019 Bit order per pixel: green[7:0], red[7:0], blue[7:0], MSB first, 24 bits per pixel.
REQ-020 The 24th bit completing a pixel, with pixel counter < NUM_LEDS:
  - latch the colors, pulse pixel_valid, drive pixel_index = pixel counter, then increment the pixel counter.
REQ-021 Latency: strand_in falling edge of bit 24 -> pixel_valid high exactly 3 clk_in cycles later.
REQ-022 Pixel counter == NUM_LEDS at completion: drop the pixel, no pixel_valid, set overflow; the counter saturates.
REQ-023 End of frame:
  - pulse frame_done if the bit count or pixel count is nonzero;
  - a nonzero partial bit count also pulses bit_error in the same cycle;
  - clear the bit counter, pixel counter and overflow.
REQ-024 Any error entry into RESYNC discards the partial pixel and clears the bit counter; the pixel counter and overflow are retained until frame end.
REQ-025 Color outputs hold their value between pixel_valid pulses.
REQ-026 Bit low-time is not checked; only high-time and the reset gap are checked.

Reset
REQ-027 rst_n_in low asynchronously forces the following:
  - state = RESYNC;
  - synchronizer flops = 0;
  - all counters = 0;
  - colors = 0, pixel_index = 0;
  - pixel_valid = frame_done = bit_error = overflow = 0.
REQ-028 Reset deassertion mid-frame: the block does not decode until the line has been low for RESCyc cycles (REQ-015).

Verification
REQ-029 Reset, line low 50us, then pixel G=0xA5 R=0x3C B=0xFF with 40/85-cycle and 80/45-cycle bits, then 50us low:
  - pixel_valid pulse with the three values and pixel_index=0, 3 cycles after the last falling edge;
  - frame_done pulse.
REQ-030 Send 21 pixels with NUM_LEDS=20:
  - indices 0..19 reported;
  - 21st pixel dropped and overflow=1;
  - overflow clears at frame_done.
REQ-031 Threshold boundary:
  - 59-cycle high decodes 0; 60-cycle high decodes 1;
  - 14-cycle high -> bit_error; 111-cycle high -> bit_error at cycle 111.
REQ-032 12 bits, then 50us low: bit_error and frame_done in the same cycle, no pixel_valid.
REQ-033 Assert rst_n_in mid-pixel: outputs return to 0 immediately; a pixel sent without a preceding 50us low is ignored.
REQ-034 Back-to-back pixels with no gap between bit 24 and bit 1: both are decoded with consecutive indices.
